// File: rtl/mlp_pkg.sv
// Shared constants, state type and element-index helper for the pixel averager.
// Optional macro: PIXEL_AVERAGER_ROUND_EN selects round-and-saturate output conversion.
package mlp_pkg;

    localparam int RESOLUTION    = 8;
    localparam int IMG_W         = 28;
    localparam int IMG_H         = 28;
    localparam int AVG_PIXELS_NR = (IMG_W / 2) * (IMG_H / 2);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } avg_state_e;

    // Packed-output element owning pixel (row, col): one element per 2x2 block
    function automatic int avg_elem_index(input int row, input int col, input int img_w);
        return (row / 2) * (img_w / 2) + (col / 2);
    endfunction

endpackage

// File: rtl/line_sum_buffer.sv
// Horizontal pair sums for even rows, held in a half-width line buffer and
// combined with the odd-row pair sum to give the 2x2 block sum.
module line_sum_buffer #(
    parameter int IMG_W      = 28,
    parameter int RESOLUTION = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    xfer,
    input  logic [$clog2(IMG_W)-1:0] col,
    input  logic                    row_odd,
    input  logic [RESOLUTION-1:0]   pixel,
    output logic                    sum_valid,
    output logic [RESOLUTION+1:0]   sum4
);
    import mlp_pkg::*;

    localparam int ENTRIES = IMG_W / 2;
    localparam int COL_W   = $clog2(IMG_W);
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int PAIR_W  = RESOLUTION + 1;
    localparam int SUM_W   = RESOLUTION + 2;

    logic [RESOLUTION-1:0] even_pix_q, even_pix_d;
    logic [PAIR_W-1:0]     line_q [ENTRIES];
    logic [PAIR_W-1:0]     line_d [ENTRIES];
    logic [PAIR_W-1:0]     pair_s;
    logic [IDX_W-1:0]      idx_s;

    // Pair-sum formation, line-buffer update and 2x2 sum output
    always_comb begin
        even_pix_d = even_pix_q;
        line_d     = line_q;
        idx_s      = IDX_W'(col[COL_W-1:1]);
        pair_s     = PAIR_W'(even_pix_q) + PAIR_W'(pixel);
        sum4       = SUM_W'(line_q[idx_s]) + SUM_W'(pair_s);
        sum_valid  = xfer & col[0] & row_odd;
        if (xfer && !col[0]) begin
            even_pix_d = pixel;
        end else if (xfer && col[0] && !row_odd) begin
            line_d[idx_s] = pair_s;
        end else begin
            even_pix_d = even_pix_q;
        end
    end

    // Even-pixel holding register and line buffer storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            even_pix_q <= {RESOLUTION{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                line_q[i] <= {PAIR_W{1'b0}};
            end
        end else begin
            even_pix_q <= even_pix_d;
            line_q     <= line_d;
        end
    end

endmodule

// File: rtl/pixel_averager.sv
// 2x2 box-average downscaler: raster pixels in, one packed frame of block averages out,
// held until acknowledged. Define PIXEL_AVERAGER_ROUND_EN for round-and-saturate output.
module pixel_averager #(
    parameter int IMG_W      = mlp_pkg::IMG_W,
    parameter int IMG_H      = mlp_pkg::IMG_H,
    parameter int RESOLUTION = mlp_pkg::RESOLUTION
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [RESOLUTION-1:0]                       pixel_in,
    input  logic                                        pixel_valid,
    input  logic                                        pixel_sof,
    output logic                                        pixel_ready,
    output logic [RESOLUTION*(IMG_W/2)*(IMG_H/2)-1:0]   averaged_pixels,
    output logic                                        frame_valid,
    input  logic                                        frame_ack,
    output logic                                        frame_error
);
    import mlp_pkg::*;

    localparam int ELEMS  = (IMG_W / 2) * (IMG_H / 2);
    localparam int VEC_W  = RESOLUTION * ELEMS;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int ELEM_W = $clog2(ELEMS);
    localparam int SUM_W  = RESOLUTION + 2;
    localparam logic [COL_W-1:0]      COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0]      COL_ONE  = {{(COL_W-1){1'b0}}, 1'b1};
    localparam logic [ROW_W-1:0]      ROW_ONE  = {{(ROW_W-1){1'b0}}, 1'b1};
    localparam logic [RESOLUTION-1:0] OUT_MAX  = {1'b0, {(RESOLUTION-1){1'b1}}};

    avg_state_e            state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d, eff_col_s;
    logic [ROW_W-1:0]      row_q, row_d, eff_row_s;
    logic [VEC_W-1:0]      avg_q, avg_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  frame_error_q, frame_error_d;
    logic                  pixel_ready_q, pixel_ready_d;
    logic                  xfer_s, sum_valid_s;
    logic [SUM_W-1:0]      sum4_s;
    logic [RESOLUTION-1:0] conv_s;
    logic [ELEM_W-1:0]     elem_idx_s;
`ifdef PIXEL_AVERAGER_ROUND_EN
    logic [SUM_W:0]        rounded_s;
`endif

    line_sum_buffer #(
        .IMG_W      (IMG_W),
        .RESOLUTION (RESOLUTION)
    ) u_line_sum_buffer (
        .clk       (clk),
        .reset     (reset),
        .xfer      (xfer_s),
        .col       (eff_col_s),
        .row_odd   (eff_row_s[0]),
        .pixel     (pixel_in),
        .sum_valid (sum_valid_s),
        .sum4      (sum4_s)
    );

    // Transfer qualification; a start-of-frame pixel is always treated as (0,0)
    always_comb begin
        xfer_s = pixel_valid & pixel_ready_q;
        if (pixel_sof) begin
            eff_col_s = {COL_W{1'b0}};
            eff_row_s = {ROW_W{1'b0}};
        end else begin
            eff_col_s = col_q;
            eff_row_s = row_q;
        end
        elem_idx_s = ELEM_W'(avg_elem_index(int'(eff_row_s), int'(eff_col_s), IMG_W));
    end

    // 2x2 sum to output element conversion
    always_comb begin
`ifdef PIXEL_AVERAGER_ROUND_EN
        rounded_s = ((SUM_W + 1)'(sum4_s) + (SUM_W + 1)'(3'd4)) >> 2'd3;
        if (rounded_s > (SUM_W + 1)'(OUT_MAX)) begin
            conv_s = OUT_MAX;
        end else begin
            conv_s = RESOLUTION'(rounded_s);
        end
`else
        conv_s = RESOLUTION'(sum4_s >> 2'd3);
`endif
    end

    // Frame FSM, raster counters, output element writes and error flag
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        avg_d         = avg_q;
        frame_valid_d = frame_valid_q;
        frame_error_d = frame_error_q;
        case (state_q)
            ACCUM: begin
                if (xfer_s) begin
                    if (pixel_sof && ((col_q != {COL_W{1'b0}}) || (row_q != {ROW_W{1'b0}}))) begin
                        frame_error_d = 1'b1;
                    end else begin
                        frame_error_d = frame_error_q;
                    end
                    if (sum_valid_s) begin
                        avg_d[int'(elem_idx_s) * RESOLUTION +: RESOLUTION] = conv_s;
                    end else begin
                        avg_d = avg_q;
                    end
                    if (eff_col_s == COL_LAST) begin
                        col_d = {COL_W{1'b0}};
                        if (eff_row_s == ROW_LAST) begin
                            row_d         = {ROW_W{1'b0}};
                            state_d       = HOLD;
                            frame_valid_d = 1'b1;
                        end else begin
                            row_d = eff_row_s + ROW_ONE;
                        end
                    end else begin
                        col_d = eff_col_s + COL_ONE;
                        row_d = eff_row_s;
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    state_d       = ACCUM;
                    frame_valid_d = 1'b0;
                    col_d         = {COL_W{1'b0}};
                    row_d         = {ROW_W{1'b0}};
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
        pixel_ready_d = (state_d == ACCUM);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ACCUM;
            col_q         <= {COL_W{1'b0}};
            row_q         <= {ROW_W{1'b0}};
            avg_q         <= {VEC_W{1'b0}};
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            pixel_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            avg_q         <= avg_d;
            frame_valid_q <= frame_valid_d;
            frame_error_q <= frame_error_d;
            pixel_ready_q <= pixel_ready_d;
        end
    end

    assign pixel_ready     = pixel_ready_q;
    assign averaged_pixels = avg_q;
    assign frame_valid     = frame_valid_q;
    assign frame_error     = frame_error_q;

endmodule
